// File: rtl/img_stream_pkg.sv
// img_stream_pkg
// Shared types and constants for the image stream controller slice.
//   state_t          controller FSM states
//   MODE_RX/MODE_TX  transfer direction encoding of the mode input
//   CSUM_W           checksum width (IMG_STREAM_CHECKSUM_EN builds only)
package img_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        TX,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_RX = 1'b0;
    localparam logic MODE_TX = 1'b1;

    localparam int CSUM_W = 16;

endpackage

// File: rtl/img_stream_if.sv
// img_stream_if
// Bundles the control, pixel stream and SRAM signals of img_stream_ctrl.
//   control : start, mode, nrows, ncols, row_base, col_base, busy, done
//   RX      : s_data, s_valid, s_ready
//   TX      : m_data, m_valid, m_ready
//   SRAM    : sram_din, sram_dout, sram_row, sram_col, sram_write_en, sram_sense_en
// slave  = controller side, master = surrounding system side.
interface img_stream_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8
) ();
    logic              start;
    logic              mode;
    logic [ROW_W-1:0]  nrows;
    logic [COL_W-1:0]  ncols;
    logic [ROW_W-1:0]  row_base;
    logic [COL_W-1:0]  col_base;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;
    logic [ROW_W-1:0]  sram_row;
    logic [COL_W-1:0]  sram_col;
    logic              sram_write_en;
    logic              sram_sense_en;

    modport slave (
        input  start, mode, nrows, ncols, row_base, col_base,
               s_data, s_valid, m_ready, sram_dout,
        output busy, done, s_ready, m_data, m_valid,
               sram_din, sram_row, sram_col, sram_write_en, sram_sense_en
    );

    modport master (
        output start, mode, nrows, ncols, row_base, col_base,
               s_data, s_valid, m_ready, sram_dout,
        input  busy, done, s_ready, m_data, m_valid,
               sram_din, sram_row, sram_col, sram_write_en, sram_sense_en
    );
endinterface

// File: rtl/img_stream_skid.sv
// img_stream_skid
// 2-entry FIFO with fall-through: a push into an empty FIFO is visible on
// dout in the same cycle, and if it is popped in that cycle it is never stored.
//   clk, rst   clock, asynchronous active-high reset (flushes the FIFO)
//   push, din  write strobe and data
//   pop        read strobe (only honoured while valid)
//   valid      head available (stored entry or fall-through push)
//   dout       head data, 0 while not valid
//   occ        number of stored entries (0..2), excludes the current push
module img_stream_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        occ
);
    logic [1:0][DATA_W-1:0] mem;
    logic                   wr_ptr, rd_ptr;
    logic                   empty, bypass, store, remove;

    assign empty  = (occ == 2'd0);
    assign valid  = !empty || push;
    assign dout   = !valid ? '0 : (empty ? din : mem[rd_ptr]);
    assign bypass = empty && push && pop;
    assign store  = push && !bypass;
    assign remove = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (remove) rd_ptr <= !rd_ptr;
            occ <= occ + {1'b0, store} - {1'b0, remove};
        end
    end
endmodule

// File: rtl/img_stream_ctrl.sv
// img_stream_ctrl
// Moves a rectangular pixel region between a valid/ready pixel stream and
// the single-port image SRAM, in raster order (column fastest).
//   clk, rst  clock, asynchronous active-high reset (aborts any transfer)
//   bus       img_stream_if.slave: control, RX stream, TX stream, SRAM port
//   csum      16-bit pixel checksum, present only when IMG_STREAM_CHECKSUM_EN
//             is defined
// RX writes each accepted beat straight to the SRAM in the same cycle.
// TX issues reads while (stored + in-flight) < 2 so the skid FIFO can
// absorb every returning word; its head drives m_data/m_valid.
module img_stream_ctrl
    import img_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    img_stream_if.slave bus
`ifdef IMG_STREAM_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] csum
`endif
);
    state_t            state;
    logic [ROW_W-1:0]  nrows_q, rbase_q, r;
    logic [COL_W-1:0]  ncols_q, cbase_q, c;
    logic              rd_inflight;
    logic              busy_q, done_q;

    logic              rx_beat, rd_issue, adv, last_pix, pop_hs, drain_empty;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_dout;
    logic [1:0]        occ;

    assign rx_beat  = (state == RX) && bus.s_valid;
    assign rd_issue = (state == TX) && ((occ + {1'b0, rd_inflight}) < 2'd2);
    assign adv      = rx_beat || rd_issue;
    assign last_pix = (r == nrows_q - ROW_W'(1)) && (c == ncols_q - COL_W'(1));
    assign pop_hs   = fifo_valid && bus.m_ready;
    // FIFO empties at this edge: stored + returning word all popped.
    assign drain_empty = ({1'b0, occ} + {2'b0, rd_inflight}) == {2'b0, pop_hs};

    assign bus.s_ready       = (state == RX);
    assign bus.sram_write_en = rx_beat;
    assign bus.sram_sense_en = !rx_beat;
    assign bus.sram_din      = rx_beat ? bus.s_data : '0;
    assign bus.sram_row      = adv ? rbase_q + r : '0;
    assign bus.sram_col      = adv ? cbase_q + c : '0;
    assign bus.m_valid       = fifo_valid;
    assign bus.m_data        = fifo_dout;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

    img_stream_skid #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_inflight),
        .din   (bus.sram_dout),
        .pop   (bus.m_ready),
        .valid (fifo_valid),
        .dout  (fifo_dout),
        .occ   (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            nrows_q     <= '0;
            ncols_q     <= '0;
            rbase_q     <= '0;
            cbase_q     <= '0;
            r           <= '0;
            c           <= '0;
            rd_inflight <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            done_q      <= 1'b0;
            if (adv) begin
                if (c == ncols_q - COL_W'(1)) begin
                    c <= '0;
                    r <= r + ROW_W'(1);
                end else begin
                    c <= c + COL_W'(1);
                end
            end
            case (state)
                IDLE: if (bus.start) begin
                    nrows_q <= bus.nrows;
                    ncols_q <= bus.ncols;
                    rbase_q <= bus.row_base;
                    cbase_q <= bus.col_base;
                    r       <= '0;
                    c       <= '0;
                    busy_q  <= 1'b1;
                    if (bus.nrows == '0 || bus.ncols == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= (bus.mode == MODE_TX) ? TX : RX;
                    end
                end
                RX: if (rx_beat && last_pix) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                TX: if (rd_issue && last_pix) state <= DRAIN;
                DRAIN: if (drain_empty) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMG_STREAM_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          csum <= '0;
        else if (state == IDLE && bus.start) csum <= '0;
        else if (rx_beat)                 csum <= csum + CSUM_W'(bus.s_data);
        else if (pop_hs)                  csum <= csum + CSUM_W'(bus.m_data);
    end
`endif
endmodule
